maj_vec_checker: RTL and testbench

Sequential stimulus-and-check stage that sits directly upstream of the mapped N-input majority netlist (`top`, ports `x0..x{N-1}` → `y0`). It drives the input vector, waits a programmable settle time, samples `y0`, and compares it against an internal popcount reference (`popcount ≥ (N+1)/2`). It counts vectors and mismatches and captures the first failing vector. This replaces exhaustive simulation loops with a synthesizable, on-chip self-check harness for folded/bias-decomposed majority mappings.

---
 rtl/maj_pkg.sv | 44 ++++
 rtl/maj_ref_popcount.sv | 24 ++
 rtl/maj_vec_checker.sv | 122 ++++++++++++
 tb/tb_maj_vec_checker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/maj_pkg.sv
// rtl/maj_pkg.sv - shared types, constants and helpers for the majority vector checker
package maj_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } maj_chk_state_t;

   localparam int MAJ_N_DEFAULT = 39;

   function automatic int maj_thresh(input int n);
      return (n + 1) / 2;
   endfunction

   // Tap index for x <= {x[N-2:0], x[N-1]^x[TAP]}; widths without a two-term
   // maximal polynomial fall back to N-2, which still cycles but not maximally.
   function automatic int maj_lfsr_tap(input int n);
      case (n)
         3:       return 1;
         5:       return 2;
         7:       return 5;
         9:       return 4;
         11:      return 8;
         15:      return 13;
         17:      return 13;
         23:      return 17;
         25:      return 21;
         31:      return 27;
         33:      return 19;
         35:      return 32;
         39:      return 34;
         41:      return 37;
         47:      return 41;
         49:      return 39;
         55:      return 30;
         57:      return 49;
         63:      return 61;
         default: return n - 2;
      endcase
   endfunction

endpackage

// File: rtl/maj_ref_popcount.sv
// rtl/maj_ref_popcount.sv - combinational popcount majority reference
module maj_ref_popcount
   import maj_pkg::*;
#(
   parameter int N = MAJ_N_DEFAULT
) (
   input  logic [N-1:0] x,
   output logic         ref_y
);

   localparam int CNT_W = $clog2(N + 1);

   logic [CNT_W-1:0] cnt;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + CNT_W'(x[i]);
      end
   end

   assign ref_y = (cnt >= CNT_W'(maj_thresh(N)));

endmodule

// File: rtl/maj_vec_checker.sv
// rtl/maj_vec_checker.sv - drives vectors into a majority netlist and checks its output
module maj_vec_checker
   import maj_pkg::*;
#(
   parameter int N      = MAJ_N_DEFAULT,
   parameter int SETTLE = 1,
   parameter int CW     = 40
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [N-1:0]  seed,
   input  logic [CW-1:0] num_vectors,
   output logic [N-1:0]  x,
   input  logic          y_dut,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] vec_cnt,
   output logic [31:0]   mismatch_cnt,
   output logic          first_fail_valid,
   output logic [N-1:0]  first_fail_vec
);

   localparam int                TAP           = maj_lfsr_tap(N);
   localparam int                SW            = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0]     SETTLE_RELOAD = SW'(SETTLE - 1);

   maj_chk_state_t  state, state_nxt;
   logic [SW-1:0]   settle_cnt;
   logic [CW-1:0]   num_vec_r;
   logic            mode_r;
   logic            ref_y;
   logic            clear, load, chk, last;
   logic [N-1:0]    first_vec, next_vec;

   maj_ref_popcount #(.N(N)) u_ref (
      .x     (x),
      .ref_y (ref_y)
   );

   assign last      = ((vec_cnt + CW'(1)) == num_vec_r);
   assign first_vec = mode ? ((seed == '0) ? N'(1) : seed) : '0;
   assign next_vec  = mode_r ? {x[N-2:0], x[N-1] ^ x[TAP]} : x + N'(1);
   assign busy      = (state == ST_SETTLE) || (state == ST_CHECK);
   assign done      = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      load      = 1'b0;
      chk       = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               clear = 1'b1;
               if (num_vectors == '0) begin
                  state_nxt = ST_DONE;
               end else begin
                  load      = 1'b1;
                  state_nxt = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_CHECK;
         ST_CHECK: begin
            chk       = 1'b1;
            state_nxt = last ? ST_DONE : ST_SETTLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x                <= '0;
         settle_cnt       <= '0;
         num_vec_r        <= '0;
         mode_r           <= 1'b0;
         vec_cnt          <= '0;
         mismatch_cnt     <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else begin
         if (clear) begin
            vec_cnt          <= '0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            mode_r           <= mode;
            num_vec_r        <= num_vectors;
         end
         if (load) begin
            x          <= first_vec;
            settle_cnt <= SETTLE_RELOAD;
         end else if (state == ST_SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
         end
         if (chk) begin
            vec_cnt <= vec_cnt + CW'(1);
            if (y_dut != ref_y) begin
               if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 32'd1;
               if (!first_fail_valid) begin
                  first_fail_valid <= 1'b1;
                  first_fail_vec   <= x;
               end
            end
            // The final vector stays on x so DONE reports what was last driven.
            if (!last) begin
               x          <= next_vec;
               settle_cnt <= SETTLE_RELOAD;
            end
         end
      end
   end

endmodule

// File: tb/tb_maj_vec_checker.sv
// tb/tb_maj_vec_checker.sv - randomized and directed self-check of maj_vec_checker
module tb_maj_vec_checker;

   localparam int N  = 39;
   localparam int CW = 40;
   localparam logic [N-1:0] MASK = {N{1'b1}};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start1 = 1'b0, start3 = 1'b0;
   logic          mode_i = 1'b0;
   logic [N-1:0]  seed_i = '0;
   logic [CW-1:0] nv_i = '0;
   int            fault_kind = 0;
   int            fault_pat = 0;
   logic          sel3 = 1'b0;

   logic [N-1:0]  x1, x3, ffv1, ffv3;
   logic          y1, y3, busy1, busy3, done1, done3, ffok1, ffok3;
   logic [CW-1:0] vc1, vc3;
   logic [31:0]   mm1, mm3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Stand-in for the mapped netlist: true majority with an optional planted fault.
   function automatic logic netlist_y(input logic [N-1:0] v, input int kind, input int pat);
      logic maj;
      maj = ($countones(v) >= 20);
      case (kind)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return maj ^ (int'(v & 39'd7) == pat);
         default: return maj;
      endcase
   endfunction

   assign y1 = netlist_y(x1, fault_kind, fault_pat);
   assign y3 = netlist_y(x3, fault_kind, fault_pat);

   maj_vec_checker #(.N(N), .SETTLE(1), .CW(CW)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .mode(mode_i), .seed(seed_i),
      .num_vectors(nv_i), .x(x1), .y_dut(y1), .busy(busy1), .done(done1),
      .vec_cnt(vc1), .mismatch_cnt(mm1), .first_fail_valid(ffok1), .first_fail_vec(ffv1)
   );

   maj_vec_checker #(.N(N), .SETTLE(3), .CW(CW)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .mode(mode_i), .seed(seed_i),
      .num_vectors(nv_i), .x(x3), .y_dut(y3), .busy(busy3), .done(done3),
      .vec_cnt(vc3), .mismatch_cnt(mm3), .first_fail_valid(ffok3), .first_fail_vec(ffv3)
   );

   logic [N-1:0]  c_x, c_ffv;
   logic          c_busy, c_done, c_ffok;
   logic [CW-1:0] c_vc;
   logic [31:0]   c_mm;
   assign c_x    = sel3 ? x3 : x1;
   assign c_ffv  = sel3 ? ffv3 : ffv1;
   assign c_busy = sel3 ? busy3 : busy1;
   assign c_done = sel3 ? done3 : done1;
   assign c_ffok = sel3 ? ffok3 : ffok1;
   assign c_vc   = sel3 ? vc3 : vc1;
   assign c_mm   = sel3 ? mm3 : mm1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input bit use3);
      @(posedge clk); #1;
      if (use3) start3 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic run_and_check(input string name, input bit use3, input bit md,
                                input logic [N-1:0] sd, input longint nv,
                                input int kind, input int pat, input int extra_at);
      logic [N-1:0] seq[$];
      logic [N-1:0] v, ff_vec;
      longint       mism, total, exp_vc;
      bit           ff_ok;
      int           s, tbad, xbad, done_at;

      s = use3 ? 3 : 1;
      sel3 = use3;
      mode_i = md; seed_i = sd; nv_i = CW'(nv);
      fault_kind = kind; fault_pat = pat;

      v = md ? ((sd == '0) ? N'(1) : sd) : '0;
      mism = 0; ff_ok = 1'b0; ff_vec = '0;
      for (longint k = 0; k < nv; k++) begin
         seq.push_back(v);
         if (netlist_y(v, kind, pat) != ($countones(v) >= 20)) begin
            mism++;
            if (!ff_ok) begin ff_ok = 1'b1; ff_vec = v; end
         end
         if (md) v = ((v << 1) | N'(v[38] ^ v[34])) & MASK;
         else    v = (v + 1) & MASK;
      end

      total = nv * (s + 1);
      tbad = 0; xbad = 0; done_at = -1;
      pulse_start(use3);
      for (int cyc = 0; cyc <= total + 2; cyc++) begin
         if (cyc > 0) begin @(posedge clk); #1; end
         exp_vc = (cyc / (s + 1) < nv) ? cyc / (s + 1) : nv;
         if (c_vc != CW'(exp_vc) || c_done != (cyc >= total) || c_busy != (cyc < total)) tbad++;
         if (c_done && done_at < 0) done_at = cyc;
         if (cyc % (s + 1) == 0 && cyc / (s + 1) < nv && c_x !== seq[cyc / (s + 1)]) xbad++;
         if (cyc == extra_at) begin
            nv_i = 5;
            if (use3) start3 = 1'b1; else start1 = 1'b1;
         end else if (cyc == extra_at + 1) begin
            start1 = 1'b0;
            start3 = 1'b0;
         end
      end

      check($sformatf("%s timing", name), 64'(tbad), 64'd0);
      check($sformatf("%s xseq", name), 64'(xbad), 64'd0);
      check($sformatf("%s done_at", name), 64'(done_at), 64'(total));
      check($sformatf("%s vec_cnt", name), 64'(c_vc), 64'(nv));
      check($sformatf("%s mismatch_cnt", name), 64'(c_mm), 64'(mism));
      check($sformatf("%s ff_valid", name), 64'(c_ffok), 64'(ff_ok));
      check($sformatf("%s ff_vec", name), 64'(c_ffv), 64'(ff_vec));
      if (nv > 0) check($sformatf("%s final_x", name), 64'(c_x), 64'(seq[nv - 1]));
   endtask

   initial begin
      logic [63:0] rnd;
      bit          u3;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset x", 64'(x1), 64'd0);
      check("reset busy", 64'(busy1), 64'd0);
      check("reset done", 64'(done1), 64'd0);
      check("reset vec_cnt", 64'(vc1), 64'd0);
      check("reset mismatch", 64'(mm1), 64'd0);
      check("reset ff", 64'({ffok1, ffv1}), 64'd0);

      run_and_check("zero_vectors", 1'b0, 1'b0, '0, 0, 0, 0, -1);
      run_and_check("exhaustive16", 1'b0, 1'b0, '0, 16, 0, 0, -1);
      run_and_check("start_busy", 1'b0, 1'b0, '0, 16, 0, 0, 7);
      run_and_check("lfsr_zero_seed", 1'b0, 1'b1, '0, 3, 2, 0, -1);
      run_and_check("stuck0_cnt", 1'b0, 1'b0, '0, 64, 1, 0, -1);
      run_and_check("stuck0_lfsr", 1'b0, 1'b1, 39'h0_000F_FFFF, 4, 1, 0, -1);
      run_and_check("settle3", 1'b1, 1'b0, '0, 4, 0, 0, -1);

      // Reset in the middle of vector 5 of a failing run.
      sel3 = 1'b0; mode_i = 1'b0; nv_i = 16; fault_kind = 2;
      pulse_start(1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("midrst pre x", 64'(x1), 64'd5);
      check("midrst pre mismatch", 64'(mm1), 64'd5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst x", 64'(x1), 64'd0);
      check("midrst counters", 64'(vc1) | 64'(mm1), 64'd0);
      check("midrst flags", 64'({ffok1, busy1, done1}), 64'd0);
      check("midrst ff_vec", 64'(ffv1), 64'd0);
      run_and_check("after_rst", 1'b0, 1'b0, '0, 16, 0, 0, -1);

      for (int r = 0; r < 8; r++) begin
         rnd = {$urandom, $urandom};
         u3  = 1'($urandom_range(0, 1));
         run_and_check($sformatf("rand%0d", r), u3, 1'($urandom_range(0, 1)),
                       rnd[N-1:0], longint'($urandom_range(1, 40)), 3,
                       int'($urandom_range(0, 7)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
